// File: rtl/input_port_pkg.sv
// Shared types for the bus-readable input port: debounce FSM states and
// the bit layout of the status word.
package input_port_pkg;

  typedef enum logic [0:0] {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } db_state_e;

  localparam int ST_DATA_READY = 0;
  localparam int ST_OVERRUN    = 1;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/input_port_synchronizer.sv
// Multi-flop synchronizer for asynchronous input pins; sync_out is in_pin
// delayed by SYNC_STAGES rising edges.
module pin_synchronizer #(
  parameter int               WIDTH       = 16,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_pin,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] stage_d [SYNC_STAGES];

  // shift chain: first stage samples the pins, the rest follow
  always_comb begin
    stage_d[0] = in_pin;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= RESET_VALUE;
      end
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign sync_out = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/input_port.sv
// Bus-readable input port: synchronizes and word-debounces external pins,
// holds the committed value and exposes data_ready/overrun status flags.
module input_port
  import input_port_pkg::*;
#(
  parameter int               WIDTH           = 16,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_pin,
  input  logic [WIDTH-1:0] in_from_bus,
  input  logic             read,
  input  logic             read_status,
  input  logic             write,
  output logic [WIDTH-1:0] out_to_bus,
  output logic [WIDTH-1:0] data_out,
  output logic             data_ready,
  output logic             overrun
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [WIDTH-1:0] sync_out;
  db_state_e        state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             data_ready_q, data_ready_d;
  logic             overrun_q, overrun_d;
  logic             commit;
  logic             ready_clr, overrun_clr, overrun_set;
  logic [WIDTH-1:0] status_word;
  logic             unused_bus_bits;

  pin_synchronizer #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VALUE (RESET_VALUE)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .in_pin   (in_pin),
    .sync_out (sync_out)
  );

  // debounce FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= STABLE;
    end else begin
      state_q <= state_d;
    end
  end

  // datapath and flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_q       <= RESET_VALUE;
      data_q       <= RESET_VALUE;
      cnt_q        <= CNT_ZERO;
      data_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      cand_q       <= cand_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      data_ready_q <= data_ready_d;
      overrun_q    <= overrun_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      STABLE: begin
        if (sync_out != data_q) state_d = SETTLING;
        else                    state_d = STABLE;
      end
      SETTLING: begin
        if (sync_out != cand_q)     state_d = SETTLING;
        else if (cnt_q == CNT_LAST) state_d = STABLE;
        else                        state_d = SETTLING;
      end
      default: state_d = STABLE;
    endcase
  end

  // candidate tracking, stability counter and commit decision
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    commit = 1'b0;
    case (state_q)
      STABLE: begin
        if (sync_out != data_q) begin
          cand_d = sync_out;
          cnt_d  = CNT_ZERO;
        end else begin
          cand_d = cand_q;
          cnt_d  = cnt_q;
        end
      end
      SETTLING: begin
        if (sync_out != cand_q) begin
          cand_d = sync_out;
          cnt_d  = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          // a candidate that settled back to the held value is a rejected glitch
          commit = (cand_q != data_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cand_d = RESET_VALUE;
        cnt_d  = CNT_ZERO;
      end
    endcase
  end

  // data register and status flags; a commit outranks any clear in the same cycle
  always_comb begin
    data_d      = commit ? cand_q : data_q;
    ready_clr   = read | (write & in_from_bus[ST_DATA_READY]);
    overrun_clr = write & in_from_bus[ST_OVERRUN];
    overrun_set = commit & data_ready_q & ~ready_clr;
    if (commit)         data_ready_d = 1'b1;
    else if (ready_clr) data_ready_d = 1'b0;
    else                data_ready_d = data_ready_q;
    if (overrun_set)      overrun_d = 1'b1;
    else if (overrun_clr) overrun_d = 1'b0;
    else                  overrun_d = overrun_q;
  end

  always_comb begin
    status_word                = {WIDTH{1'b0}};
    status_word[ST_DATA_READY] = data_ready_q;
    status_word[ST_OVERRUN]    = overrun_q;
  end

  assign out_to_bus = read        ? data_q :
                      read_status ? status_word :
                                    {WIDTH{1'bz}};

  assign data_out        = data_q;
  assign data_ready      = data_ready_q;
  assign overrun         = overrun_q;
  assign unused_bus_bits = ^in_from_bus[WIDTH-1:2];

endmodule

// File: tb/tb_input_port.sv
// Randomized self-checking bench for input_port against a run-length
// reference model of the synchronizer, debouncer and status flags.
module tb_input_port;

  localparam int S = 2;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_pin;
  logic [15:0] in_from_bus;
  logic        read;
  logic        read_status;
  logic        write;
  wire  [15:0] out_to_bus;
  logic [15:0] data_out;
  logic        data_ready;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [15:0] sq[$];
  logic [15:0] run_val;
  int          run_len;
  logic [15:0] m_data;
  bit          m_dr;
  bit          m_ov;

  input_port #(
    .WIDTH           (16),
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D),
    .RESET_VALUE     (16'h0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_pin      (in_pin),
    .in_from_bus (in_from_bus),
    .read        (read),
    .read_status (read_status),
    .write       (write),
    .out_to_bus  (out_to_bus),
    .data_out    (data_out),
    .data_ready  (data_ready),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    sq.delete();
    for (int i = 0; i < S; i++) sq.push_back(16'h0000);
    run_val = 16'h0000;
    run_len = 1;
    m_data  = 16'h0000;
    m_dr    = 1'b0;
    m_ov    = 1'b0;
  endfunction

  // a value commits once the debouncer has seen it D+1 times in a row and it differs from the held value
  function automatic bit peek_commit();
    logic [15:0] s;
    int          len;
    s   = sq[0];
    len = (s == run_val) ? run_len + 1 : 1;
    return (len >= D + 1) && (s != m_data);
  endfunction

  function automatic void model_edge();
    logic [15:0] s;
    bit          commit;
    bit          dr_clr;
    bit          new_dr;
    bit          new_ov;
    s = sq.pop_front();
    sq.push_back(in_pin);
    if (s == run_val) begin
      if (run_len <= D) run_len++;
    end else begin
      run_val = s;
      run_len = 1;
    end
    commit = (run_len >= D + 1) && (s != m_data);
    dr_clr = read || (write && in_from_bus[0]);
    new_dr = commit ? 1'b1 : (dr_clr ? 1'b0 : m_dr);
    new_ov = (commit && m_dr && !dr_clr) ? 1'b1 : ((write && in_from_bus[1]) ? 1'b0 : m_ov);
    if (commit) m_data = s;
    m_dr = new_dr;
    m_ov = new_ov;
  endfunction

  task automatic step();
    logic [15:0] exp_bus;
    #1;
    exp_bus = read ? m_data : (read_status ? {14'b0, m_ov, m_dr} : 16'hzzzz);
    check_eq("bus", out_to_bus, exp_bus);
    model_edge();
    @(posedge clk);
    #1;
    check_eq("data_out", data_out, m_data);
    check_eq("data_ready", {15'b0, data_ready}, {15'b0, m_dr});
    check_eq("overrun", {15'b0, overrun}, {15'b0, m_ov});
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    read        = 1'b0;
    read_status = 1'b0;
    write       = 1'b0;
    #1;
    model_reset();
    check_eq("rst_data_out", data_out, 16'h0000);
    check_eq("rst_flags", {14'b0, overrun, data_ready}, 16'h0000);
    check_eq("rst_bus_z", out_to_bus, 16'hzzzz);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic hold_until(input logic [15:0] v, input int exp_edges, input string tag);
    int found;
    found  = -1;
    in_pin = v;
    for (int i = 0; i < 20; i++) begin
      step();
      if (found < 0 && data_out === v) found = i;
    end
    check_eq(tag, 16'(found), 16'(exp_edges));
  endtask

  initial begin
    logic [15:0] pick;
    in_pin      = 16'h0000;
    in_from_bus = 16'h0000;
    read        = 1'b0;
    read_status = 1'b0;
    write       = 1'b0;
    reset       = 1'b0;

    // 1: reset and idle
    do_reset();
    for (int i = 0; i < 4; i++) step();

    // 3: short glitch is rejected
    in_pin = 16'h00FF;
    step();
    step();
    in_pin = 16'h0000;
    for (int i = 0; i < 10; i++) step();
    check_eq("glitch_data", data_out, 16'h0000);
    check_eq("glitch_flags", {14'b0, overrun, data_ready}, 16'h0000);

    // 2: commit latency, then read clears data_ready
    hold_until(16'hA5A5, S + D, "latency_a5a5");
    check_eq("a5_ready", {15'b0, data_ready}, 16'h0001);
    read = 1'b1;
    #1;
    check_eq("a5_bus", out_to_bus, 16'hA5A5);
    step();
    read = 1'b0;
    check_eq("a5_ready_clr", {15'b0, data_ready}, 16'h0000);

    // 4: two commits without a read raise overrun; W1C clears it
    in_pin = 16'h1111;
    for (int i = 0; i < 10; i++) step();
    in_pin = 16'h2222;
    for (int i = 0; i < 10; i++) step();
    check_eq("ovr_data", data_out, 16'h2222);
    check_eq("ovr_set", {15'b0, overrun}, 16'h0001);
    read_status = 1'b1;
    #1;
    check_eq("status_word", out_to_bus, 16'h0003);
    step();
    read_status = 1'b0;
    write       = 1'b1;
    in_from_bus = 16'h0002;
    step();
    write = 1'b0;
    check_eq("ovr_clr", {15'b0, overrun}, 16'h0000);
    check_eq("ovr_ready_kept", {15'b0, data_ready}, 16'h0001);

    // 5: commit in the same cycle as a read
    write       = 1'b1;
    in_from_bus = 16'h0003;
    step();
    write  = 1'b0;
    in_pin = 16'h3C3C;
    for (int i = 0; i < 12; i++) begin
      read = peek_commit();
      if (read) begin
        #1;
        check_eq("coinc_bus_old", out_to_bus, 16'h2222);
      end
      step();
      read = 1'b0;
    end
    check_eq("coinc_data", data_out, 16'h3C3C);
    check_eq("coinc_ready", {15'b0, data_ready}, 16'h0001);
    check_eq("coinc_ovr", {15'b0, overrun}, 16'h0000);

    // 6: reset while settling discards the candidate
    in_pin = 16'hFFFF;
    for (int i = 0; i < 3; i++) step();
    do_reset();
    hold_until(16'hFFFF, S + D, "latency_after_reset");

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 249) == 0) do_reset();
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0:       pick = 16'($urandom);
          1:       pick = 16'h0F0F;
          2:       pick = 16'hF0F0;
          default: pick = 16'h0000;
        endcase
        in_pin = pick;
      end
      read        = ($urandom_range(0, 7) == 0);
      read_status = ($urandom_range(0, 5) == 0);
      write       = ($urandom_range(0, 7) == 0);
      in_from_bus = 16'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
